// File: rtl/llc_cmd_sequencer.sv
// Command sequencer feeding the LLC: separate processor and snoop queues, a barrier
// register for control ops, and a single registered valid/ready output stage.
module llc_cmd_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SNOOP_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(SNOOP_BURST + 1);
  localparam logic [PW:0] PtrOne = (PW + 1)'(1);

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t        p_mem [DEPTH];
  cmd_t        s_mem [DEPTH];
  logic [PW:0] p_wr_q, p_rd_q, s_wr_q, s_rd_q;
  logic        b_valid_q;
  cmd_t        b_cmd_q;
  logic        out_valid_q;
  cmd_t        out_q;
  logic [15:0] drop_q;
  logic [SW-1:0] streak_q;

  logic is_p, is_s, is_b, is_ill;
  logic p_empty, s_empty, p_full, s_full;
  logic accept, load, burst_done;
  logic sel_s, sel_p, sel_b;
  cmd_t in_cmd;

  assign in_cmd = {in_op, in_addr};

  always_comb begin
    is_p   = (in_op <= 4'd2);
    is_s   = (in_op >= 4'd3) && (in_op <= 4'd6);
    is_b   = (in_op == 4'd8) || (in_op == 4'd9);
    is_ill = !(is_p || is_s || is_b);
  end

  assign p_empty = (p_wr_q == p_rd_q);
  assign s_empty = (s_wr_q == s_rd_q);
  assign p_full  = (p_wr_q[PW] != p_rd_q[PW]) && (p_wr_q[PW-1:0] == p_rd_q[PW-1:0]);
  assign s_full  = (s_wr_q[PW] != s_rd_q[PW]) && (s_wr_q[PW-1:0] == s_rd_q[PW-1:0]);

  // A pending barrier blocks all input so nothing can overtake it.
  always_comb begin
    in_ready = 1'b0;
    if (!b_valid_q) begin
      if (is_p)      in_ready = !p_full;
      else if (is_s) in_ready = !s_full;
      else           in_ready = 1'b1;
    end
  end

  assign accept     = in_valid && in_ready;
  assign load       = !out_valid_q || out_ready;
  assign burst_done = !p_empty && (streak_q == SW'(SNOOP_BURST));

  always_comb begin
    sel_s = load && !s_empty && !burst_done;
    sel_p = load && !sel_s && !p_empty;
    sel_b = load && b_valid_q && p_empty && s_empty;
  end

  always_ff @(posedge clk) begin
    if (accept && is_p) p_mem[p_wr_q[PW-1:0]] <= in_cmd;
    if (accept && is_s) s_mem[s_wr_q[PW-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_wr_q      <= '0;
      p_rd_q      <= '0;
      s_wr_q      <= '0;
      s_rd_q      <= '0;
      b_valid_q   <= 1'b0;
      b_cmd_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      drop_q      <= '0;
      streak_q    <= '0;
    end else begin
      if (accept && is_p) p_wr_q <= p_wr_q + PtrOne;
      if (accept && is_s) s_wr_q <= s_wr_q + PtrOne;
      if (accept && is_b) begin
        b_valid_q <= 1'b1;
        b_cmd_q   <= in_cmd;
      end
      if (accept && is_ill && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

      if (sel_s) begin
        out_valid_q <= 1'b1;
        out_q       <= s_mem[s_rd_q[PW-1:0]];
        s_rd_q      <= s_rd_q + PtrOne;
        streak_q    <= p_empty ? '0 : streak_q + SW'(1);
      end else if (sel_p) begin
        out_valid_q <= 1'b1;
        out_q       <= p_mem[p_rd_q[PW-1:0]];
        p_rd_q      <= p_rd_q + PtrOne;
        streak_q    <= '0;
      end else if (sel_b) begin
        out_valid_q <= 1'b1;
        out_q       <= b_cmd_q;
        b_valid_q   <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_q.op;
  assign out_addr   = out_q.addr;
  assign drop_count = drop_q;
  assign busy       = !p_empty || !s_empty || b_valid_q || out_valid_q;

endmodule
